// File: rtl/two_input_or10_pkg.sv
// rtl/two_input_or10_pkg.sv - shared select codes and default width for two_input_or10
package two_input_or10_pkg;

    localparam int DEFAULT_WIDTH = 17;

    localparam logic [2:0] SEL_IN1  = 3'd0;
    localparam logic [2:0] SEL_IN2  = 3'd1;
    localparam logic [2:0] SEL_OR   = 3'd2;
    localparam logic [2:0] SEL_AND  = 3'd3;
    localparam logic [2:0] SEL_XOR  = 3'd4;
    localparam logic [2:0] SEL_NOR  = 3'd5;
    localparam logic [2:0] SEL_HOLD = 3'd6;
    localparam logic [2:0] SEL_ZERO = 3'd7;

endpackage

// File: rtl/two_input_or10_logic.sv
// rtl/two_input_or10_logic.sv - combinational operation select for two_input_or10
module two_input_or10_logic
    import two_input_or10_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [WIDTH-1:0] current,
    input  logic [2:0]       selection,
    output logic [WIDTH-1:0] result
);

    // Pick the next register value; hold feeds the current register value back.
    always_comb begin
        result = '0;
        case (selection)
            SEL_IN1:  result = input1;
            SEL_IN2:  result = input2;
            SEL_OR:   result = input1 | input2;
            SEL_AND:  result = input1 & input2;
            SEL_XOR:  result = input1 ^ input2;
            SEL_NOR:  result = ~(input1 | input2);
            SEL_HOLD: result = current;
            SEL_ZERO: result = '0;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/two_input_or10.sv
// rtl/two_input_or10.sv - registered bitwise operation unit; optional Zero flag via TWO_INPUT_OR10_ZFLAG_EN
module two_input_or10
    import two_input_or10_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Input1,
    input  logic [WIDTH-1:0] Input2,
    input  logic [2:0]       Selection,
`ifdef TWO_INPUT_OR10_ZFLAG_EN
    output logic             Zero,
`endif
    output logic [WIDTH-1:0] Output
);

    logic [WIDTH-1:0] next_result;

    two_input_or10_logic #(
        .WIDTH (WIDTH)
    ) u_logic (
        .input1    (Input1),
        .input2    (Input2),
        .current   (Output),
        .selection (Selection),
        .result    (next_result)
    );

    // Output register; reset wins over every select code, including hold.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Output <= '0;
        end else begin
            Output <= next_result;
        end
    end

`ifdef TWO_INPUT_OR10_ZFLAG_EN
    // Zero flag tracks the value being loaded into Output and freezes during hold.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Zero <= 1'b1;
        end else if (Selection != SEL_HOLD) begin
            Zero <= (next_result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_two_input_or10.sv
// tb/tb_two_input_or10.sv - directed self-checking bench for two_input_or10
module tb_two_input_or10;
    import two_input_or10_pkg::*;

    localparam int WIDTH = 17;

    logic             Clock;
    logic             Reset;
    logic [WIDTH-1:0] Input1;
    logic [WIDTH-1:0] Input2;
    logic [2:0]       Selection;
    logic [WIDTH-1:0] Output;
`ifdef TWO_INPUT_OR10_ZFLAG_EN
    logic             Zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    two_input_or10 #(
        .WIDTH (WIDTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Input1    (Input1),
        .Input2    (Input2),
        .Selection (Selection),
`ifdef TWO_INPUT_OR10_ZFLAG_EN
        .Zero      (Zero),
`endif
        .Output    (Output)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply(input logic [2:0] sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        Selection = sel;
        Input1    = a;
        Input2    = b;
        step();
    endtask

    task automatic check_zero(input string tag, input logic expected);
`ifdef TWO_INPUT_OR10_ZFLAG_EN
        check(tag, {31'd0, Zero}, {31'd0, expected});
`else
        if (tag.len() == 0 && expected) $display("unused");
`endif
    endtask

    initial begin
        Reset     = 1'b1;
        Input1    = 17'd5;
        Input2    = 17'd15;
        Selection = SEL_OR;
        step();
        step();
        check("reset_out", {15'd0, Output}, 32'd0);
        check_zero("reset_zero", 1'b1);

        Reset = 1'b0;
        apply(SEL_IN1, 17'd5, 17'd15);
        check("pass_in1", {15'd0, Output}, 32'd5);
        check_zero("pass_in1_zero", 1'b0);
        apply(SEL_IN2, 17'd5, 17'd15);
        check("pass_in2", {15'd0, Output}, 32'd15);
        apply(SEL_OR, 17'd5, 17'd15);
        check("or", {15'd0, Output}, 32'd15);
        apply(SEL_AND, 17'd5, 17'd15);
        check("and", {15'd0, Output}, 32'd5);
        apply(SEL_XOR, 17'd5, 17'd15);
        check("xor", {15'd0, Output}, 32'd10);
        apply(SEL_NOR, 17'd5, 17'd15);
        check("nor", {15'd0, Output}, 32'h1FFF0);
        apply(SEL_ZERO, 17'd5, 17'd15);
        check("zero_code", {15'd0, Output}, 32'd0);
        check_zero("zero_code_flag", 1'b1);

        apply(SEL_IN2, 17'd5, 17'd15);
        check("hold_setup", {15'd0, Output}, 32'd15);
        for (int i = 0; i < 3; i++) begin
            apply(SEL_HOLD, 17'h1FFFF, 17'd0);
            check($sformatf("hold_%0d", i), {15'd0, Output}, 32'd15);
            check_zero($sformatf("hold_zero_%0d", i), 1'b0);
        end

        apply(SEL_XOR, 17'h1FFFF, 17'h10000);
        check("width_xor", {15'd0, Output}, 32'h0FFFF);
        apply(SEL_OR, 17'h1FFFF, 17'h10000);
        check("width_or", {15'd0, Output}, 32'h1FFFF);
        apply(SEL_NOR, 17'h1FFFF, 17'h10000);
        check("width_nor", {15'd0, Output}, 32'd0);

        apply(SEL_IN1, 17'd5, 17'd15);
        check("prio_setup", {15'd0, Output}, 32'd5);
        Reset = 1'b1;
        apply(SEL_HOLD, 17'd5, 17'd15);
        check("prio_reset", {15'd0, Output}, 32'd0);
        check_zero("prio_reset_zero", 1'b1);
        Reset = 1'b0;
        apply(SEL_IN1, 17'd5, 17'd15);
        check("prio_recover", {15'd0, Output}, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
